// File: rtl/operand_fetch_pkg.sv
// Shared types and constants for the operand fetch stage.
package operand_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        HOLD   = 2'd3
    } fetch_state_t;

    // Shift codes understood by the downstream shifter.
    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

endpackage

// File: rtl/operand_fetch_stage_reg_file.sv
// Register file: one synchronous write port and one combinational read port.
// Reads return stored contents only, so a write on the same edge as a read
// capture is not forwarded.
module reg_file #(
    parameter int data_width     = 16,
    parameter int reg_addr_width = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [reg_addr_width-1:0] wr_num,
    input  logic [data_width-1:0]     wr_data,
    input  logic [reg_addr_width-1:0] rd_num,
    output logic [data_width-1:0]     rd_data
);

    localparam int num_regs = 2 ** reg_addr_width;

    logic [data_width-1:0] r_regs [num_regs];

    // Storage array: cleared on reset, written on any edge with wr_en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < num_regs; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wr_en) begin
            r_regs[wr_num] <= wr_data;
        end
    end

    // Combinational read of the stored value.
    always_comb begin
        rd_data = r_regs[rd_num];
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: fetches Rn into A and Rm into B through a single
// register-file read port over two cycles, then holds the operands for the
// shifter/ALU until the downstream handshake.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   IDLE   | ready for a request; request fields captured on accept
//   LOAD_A | read port on captured rn; A latched at the edge
//   LOAD_B | read port on captured rm; B and shift latched at the edge
//   HOLD   | operands valid; leave on an edge with out_ready
module operand_fetch_stage
    import operand_fetch_pkg::*;
#(
    parameter int data_width     = 16,
    parameter int reg_addr_width = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [reg_addr_width-1:0] wr_num,
    input  logic [data_width-1:0]     wr_data,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [reg_addr_width-1:0] req_rn,
    input  logic [reg_addr_width-1:0] req_rm,
    input  logic [1:0]                req_shift,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [data_width-1:0]     a_out,
    output logic [data_width-1:0]     b_out,
    output logic [1:0]                shift_out,
    output logic                      busy
);

    fetch_state_t r_state;
    fetch_state_t w_next_state;

    logic                      w_accept;
    logic                      w_load_a;
    logic                      w_load_b;

    logic [reg_addr_width-1:0] r_rn;
    logic [reg_addr_width-1:0] r_rm;
    logic [1:0]                r_shift;

    logic [data_width-1:0]     r_a;
    logic [data_width-1:0]     r_b;
    logic [1:0]                r_shift_out;

    logic [reg_addr_width-1:0] w_rd_num;
    logic [data_width-1:0]     w_rd_data;

    reg_file #(
        .data_width     (data_width),
        .reg_addr_width (reg_addr_width)
    ) u_rf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_num  (wr_num),
        .wr_data (wr_data),
        .rd_num  (w_rd_num),
        .rd_data (w_rd_data)
    );

    // State register; reset drops any in-flight request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-state load strobes.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_load_a     = 1'b0;
        w_load_b     = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = LOAD_A;
                end
            end
            LOAD_A: begin
                w_load_a     = 1'b1;
                w_next_state = LOAD_B;
            end
            LOAD_B: begin
                w_load_b     = 1'b1;
                w_next_state = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Single read port: rm is only needed while loading B.
    always_comb begin
        w_rd_num = (r_state == LOAD_B) ? r_rm : r_rn;
    end

    // Request capture latches, written only on the accepting edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rn    <= '0;
            r_rm    <= '0;
            r_shift <= SH_NONE;
        end else if (w_accept) begin
            r_rn    <= req_rn;
            r_rm    <= req_rm;
            r_shift <= req_shift;
        end
    end

    // Operand A latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a <= '0;
        end else if (w_load_a) begin
            r_a <= w_rd_data;
        end
    end

    // Operand B and shift-code latches, loaded together so they become
    // visible in the same cycle as out_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_b         <= '0;
            r_shift_out <= SH_NONE;
        end else if (w_load_b) begin
            r_b         <= w_rd_data;
            r_shift_out <= r_shift;
        end
    end

    // Output decode; req_ready is held low while reset is asserted.
    always_comb begin
        req_ready = (r_state == IDLE) && !reset;
        out_valid = (r_state == HOLD);
        busy      = (r_state != IDLE);
        a_out     = r_a;
        b_out     = r_b;
        shift_out = r_shift_out;
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: directed table, hand-written
// corner sequences and randomized fetches against a register-array model.
module tb_operand_fetch_stage;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_num;
    logic [15:0] wr_data;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_rn;
    logic [2:0]  req_rm;
    logic [1:0]  req_shift;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] a_out;
    logic [15:0] b_out;
    logic [1:0]  shift_out;
    logic        busy;

    int n_tests;
    int n_fail;

    logic [15:0] m_regs [8];

    operand_fetch_stage #(
        .data_width     (16),
        .reg_addr_width (3)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_num    (wr_num),
        .wr_data   (wr_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rn    (req_rn),
        .req_rm    (req_rm),
        .req_shift (req_shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_out     (a_out),
        .b_out     (b_out),
        .shift_out (shift_out),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Shifter reference: none, shift left 1, logical right 1, arithmetic right 1.
    function automatic logic [15:0] shifter(input logic [15:0] v, input logic [1:0] sh);
        case (sh)
            2'b01:   return {v[14:0], 1'b0};
            2'b10:   return {1'b0, v[15:1]};
            2'b11:   return {v[15], v[15:1]};
            default: return v;
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    endtask

    // Called at posedge+1; returns at posedge+1.
    task automatic write_reg(input logic [2:0] num, input logic [15:0] data);
        wr_en   = 1'b1;
        wr_num  = num;
        wr_data = data;
        @(posedge clk); #1;
        wr_en = 1'b0;
        m_regs[num] = data;
    endtask

    // One complete fetch. col = 1 puts a register write on the A-latch edge,
    // col = 2 on the B-latch edge. Checks against the model and returns the
    // observed operands. Called and returns at posedge+1 in IDLE.
    task automatic fetch(input logic [2:0] rn, input logic [2:0] rm, input logic [1:0] sh,
                         input int stall, input int col,
                         input logic [2:0] col_num, input logic [15:0] col_data,
                         output logic [15:0] a_act, output logic [15:0] b_act,
                         output logic [1:0] s_act);
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        chk("req_ready_idle", 16'(req_ready), 16'h1);
        req_valid = 1'b1;
        req_rn    = rn;
        req_rm    = rm;
        req_shift = sh;
        @(posedge clk); #1;                         // E0 accept
        req_valid = 1'b0;
        chk("busy_after_accept", 16'(busy), 16'h1);
        chk("req_ready_busy", 16'(req_ready), 16'h0);
        chk("out_valid_E0", 16'(out_valid), 16'h0);
        if (col == 1) begin
            wr_en = 1'b1; wr_num = col_num; wr_data = col_data;
        end
        exp_a = m_regs[rn];
        @(posedge clk); #1;                         // E1 latch A
        wr_en = 1'b0;
        if (col == 1) m_regs[col_num] = col_data;
        chk("out_valid_E1", 16'(out_valid), 16'h0);
        chk("a_after_E1", a_out, exp_a);
        if (col == 2) begin
            wr_en = 1'b1; wr_num = col_num; wr_data = col_data;
        end
        if (stall > 0) out_ready = 1'b0;
        exp_b = m_regs[rm];
        @(posedge clk); #1;                         // E2 latch B
        wr_en = 1'b0;
        if (col == 2) m_regs[col_num] = col_data;
        chk("out_valid_E2", 16'(out_valid), 16'h1);
        chk("a_out", a_out, exp_a);
        chk("b_out", b_out, exp_b);
        chk("shift_out", 16'(shift_out), 16'(sh));
        a_act = a_out;
        b_act = b_out;
        s_act = shift_out;
        for (int k = 0; k < stall; k++) begin
            req_valid = (k % 2 == 0);
            req_rn    = 3'($urandom_range(0, 7));
            req_rm    = 3'($urandom_range(0, 7));
            req_shift = 2'($urandom_range(0, 3));
            @(posedge clk); #1;
            chk("hold_valid", 16'(out_valid), 16'h1);
            chk("hold_a", a_out, exp_a);
            chk("hold_b", b_out, exp_b);
            chk("hold_shift", 16'(shift_out), 16'(sh));
        end
        req_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;                         // handshake edge
        chk("idle_valid", 16'(out_valid), 16'h0);
        chk("idle_busy", 16'(busy), 16'h0);
        chk("idle_ready", 16'(req_ready), 16'h1);
    endtask

    typedef struct {
        bit          do_wr;
        logic [2:0]  wr_num;
        logic [15:0] wr_data;
        bit          do_fetch;
        logic [2:0]  rn;
        logic [2:0]  rm;
        logic [1:0]  sh;
        int          stall;
        int          col;
        logic [2:0]  col_num;
        logic [15:0] col_data;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } vec_t;

    vec_t vecs [11];

    initial begin
        logic [15:0] a_r;
        logic [15:0] b_r;
        logic [1:0]  s_r;
        int          acc[$];
        int          waited;

        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        wr_en     = 1'b0;
        wr_num    = '0;
        wr_data   = '0;
        req_valid = 1'b0;
        req_rn    = '0;
        req_rm    = '0;
        req_shift = '0;
        out_ready = 1'b1;
        model_clear();

        vecs[0]  = '{1, 3'd3, 16'hF0CF, 0, 3'd0, 3'd0, 2'b00, 0, 0, 3'd0, 16'h0000, 16'h0000, 16'h0000};
        vecs[1]  = '{1, 3'd5, 16'h1234, 1, 3'd5, 3'd3, 2'b01, 0, 0, 3'd0, 16'h0000, 16'h1234, 16'hF0CF};
        vecs[2]  = '{0, 3'd0, 16'h0000, 1, 3'd5, 3'd3, 2'b11, 5, 0, 3'd0, 16'h0000, 16'h1234, 16'hF0CF};
        vecs[3]  = '{1, 3'd2, 16'h0001, 0, 3'd0, 3'd0, 2'b00, 0, 0, 3'd0, 16'h0000, 16'h0000, 16'h0000};
        vecs[4]  = '{0, 3'd0, 16'h0000, 1, 3'd5, 3'd2, 2'b00, 0, 2, 3'd2, 16'hAAAA, 16'h1234, 16'h0001};
        vecs[5]  = '{0, 3'd0, 16'h0000, 1, 3'd5, 3'd2, 2'b00, 0, 0, 3'd0, 16'h0000, 16'h1234, 16'hAAAA};
        vecs[6]  = '{1, 3'd7, 16'h8000, 1, 3'd7, 3'd7, 2'b10, 0, 0, 3'd0, 16'h0000, 16'h8000, 16'h8000};
        vecs[7]  = '{0, 3'd0, 16'h0000, 1, 3'd0, 3'd7, 2'b00, 1, 1, 3'd0, 16'h5555, 16'h0000, 16'h8000};
        vecs[8]  = '{0, 3'd0, 16'h0000, 1, 3'd0, 3'd0, 2'b01, 0, 0, 3'd0, 16'h0000, 16'h5555, 16'h5555};
        vecs[9]  = '{0, 3'd0, 16'h0000, 1, 3'd4, 3'd0, 2'b00, 0, 1, 3'd4, 16'h0F0F, 16'h0000, 16'h5555};
        vecs[10] = '{0, 3'd0, 16'h0000, 1, 3'd1, 3'd1, 2'b10, 2, 1, 3'd1, 16'h7777, 16'h0000, 16'h7777};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 16'(out_valid), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_req_ready", 16'(req_ready), 16'h1);
        chk("rst_a", a_out, 16'h0000);
        chk("rst_b", b_out, 16'h0000);
        chk("rst_shift", 16'(shift_out), 16'h0);
        @(posedge clk); #1;

        // Directed table.
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].do_wr) write_reg(vecs[i].wr_num, vecs[i].wr_data);
            if (vecs[i].do_fetch) begin
                fetch(vecs[i].rn, vecs[i].rm, vecs[i].sh, vecs[i].stall, vecs[i].col,
                      vecs[i].col_num, vecs[i].col_data, a_r, b_r, s_r);
                chk($sformatf("vec%0d_a", i), a_r, vecs[i].exp_a);
                chk($sformatf("vec%0d_b", i), b_r, vecs[i].exp_b);
                chk($sformatf("vec%0d_shift", i), 16'(s_r), 16'(vecs[i].sh));
                if (i == 1) chk("vec1_shifter", shifter(b_r, s_r), 16'b1110_0001_1001_1110);
            end
        end

        // Reset in the middle of the B load.
        write_reg(3'd6, 16'hBEEF);
        req_valid = 1'b1; req_rn = 3'd6; req_rm = 3'd6; req_shift = 2'b11;
        @(posedge clk); #1;                         // E0
        req_valid = 1'b0;
        @(posedge clk); #1;                         // E1
        chk("mid_a_loaded", a_out, 16'hBEEF);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 16'(out_valid), 16'h0);
        chk("mid_rst_a", a_out, 16'h0000);
        chk("mid_rst_busy", 16'(busy), 16'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
        #1;
        chk("mid_rel_ready", 16'(req_ready), 16'h1);
        chk("mid_rel_b", b_out, 16'h0000);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            fetch(3'(i), 3'(i + 4), 2'b00, 0, 0, 3'd0, 16'h0, a_r, b_r, s_r);
        end

        // Randomized writes and fetches against the model.
        for (int t = 0; t < 60; t++) begin
            int nw;
            nw = $urandom_range(0, 2);
            for (int w = 0; w < nw; w++) begin
                write_reg(3'($urandom_range(0, 7)), 16'($urandom));
            end
            fetch(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 2),
                  3'($urandom_range(0, 7)), 16'($urandom), a_r, b_r, s_r);
        end

        // Back-to-back requests with req_valid held high.
        req_valid = 1'b1; req_rn = 3'd2; req_rm = 3'd5; req_shift = 2'b01;
        out_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            chk("b2b_busy_vs_ready", 16'(busy), 16'(!req_ready));
            if (req_ready) acc.push_back(c);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk("b2b_accepts", 16'(acc.size()), 16'd6);
        for (int i = 1; i < acc.size(); i++) begin
            chk("b2b_spacing", 16'(acc[i] - acc[i-1]), 16'd4);
        end
        waited = 0;
        while (busy && waited < 8) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("b2b_drain_idle", 16'(busy), 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
